// File: rtl/instgen.sv
// Convolution instruction generator: latches one layer descriptor and walks the
// output map in raster order, issuing one stride instruction per output pixel.
module instgen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] feature_baseaddr,
    input  logic [ADDR_WIDTH-1:0] kernel_baseaddr,
    input  logic [ADDR_WIDTH-1:0] output_baseaddr,
    input  logic [DATA_WIDTH-1:0] feature_width,
    input  logic [DATA_WIDTH-1:0] feature_height,
    input  logic [DATA_WIDTH-1:0] feature_chin,
    input  logic [DATA_WIDTH-1:0] feature_chout,
    input  logic [DATA_WIDTH-1:0] kernel_sizeh,
    input  logic [DATA_WIDTH-1:0] kernel_sizew,
    input  logic                  has_bias,
    input  logic                  has_relu,
    input  logic [DATA_WIDTH-1:0] stride,
    input  logic [DATA_WIDTH-1:0] output_width,
    input  logic [DATA_WIDTH-1:0] output_height,
    input  logic                  csrcmd_valid,
    output logic                  instgen_ready,
    output logic                  inst_valid,
    input  logic                  decoder_ready,
    output logic                  conv_complete,
    output logic [ADDR_WIDTH-1:0] stride_feature_baseaddr,
    output logic [ADDR_WIDTH-1:0] stride_kernel_baseaddr,
    output logic [ADDR_WIDTH-1:0] stride_wb_baseaddr,
    output logic [DATA_WIDTH-1:0] stride_feature_chin,
    output logic [DATA_WIDTH-1:0] stride_feature_chout,
    output logic [DATA_WIDTH-1:0] stride_feature_width,
    output logic [DATA_WIDTH-1:0] stride_feature_height,
    output logic [DATA_WIDTH-1:0] stride_kernel_sizeh,
    output logic [DATA_WIDTH-1:0] stride_kernel_sizew,
    output logic [DATA_WIDTH-1:0] stride_wb_ch_offset,
    output logic                  stride_has_bias,
    output logic                  stride_has_relu
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] fbase_q, kbase_q, obase_q;
    logic [DATA_WIDTH-1:0] fw_q, fh_q, chin_q, chout_q, kh_q, kw_q;
    logic [DATA_WIDTH-1:0] stride_q, ow_q, oh_q;
    logic                  bias_q, relu_q;

    logic [DATA_WIDTH-1:0] ox_q, oy_q, row_step_q, plane_q;
    logic [ADDR_WIDTH-1:0] feat_q, row_feat_q, wb_q, row_wb_q;

    logic                  instgen_ready_q, inst_valid_q, conv_complete_q;

    logic xfer_s;
    logic last_col_s;
    logic last_row_s;

    assign xfer_s     = (state == ISSUE) && decoder_ready;
    assign last_col_s = (ox_q == (ow_q - DATA_WIDTH'(1)));
    assign last_row_s = (oy_q == (oh_q - DATA_WIDTH'(1)));

    // Next-state logic for the layer walk
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (csrcmd_valid) begin
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if ((ow_q == '0) || (oh_q == '0)) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (xfer_s && last_col_s && last_row_s) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Descriptor latch, only open while idle
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fbase_q  <= '0;
            kbase_q  <= '0;
            obase_q  <= '0;
            fw_q     <= '0;
            fh_q     <= '0;
            chin_q   <= '0;
            chout_q  <= '0;
            kh_q     <= '0;
            kw_q     <= '0;
            stride_q <= '0;
            ow_q     <= '0;
            oh_q     <= '0;
            bias_q   <= 1'b0;
            relu_q   <= 1'b0;
        end else if ((state == IDLE) && csrcmd_valid) begin
            fbase_q  <= feature_baseaddr;
            kbase_q  <= kernel_baseaddr;
            obase_q  <= output_baseaddr;
            fw_q     <= feature_width;
            fh_q     <= feature_height;
            chin_q   <= feature_chin;
            chout_q  <= feature_chout;
            kh_q     <= kernel_sizeh;
            kw_q     <= kernel_sizew;
            stride_q <= stride;
            ow_q     <= output_width;
            oh_q     <= output_height;
            bias_q   <= has_bias;
            relu_q   <= has_relu;
        end
    end

    // Pixel counters and incremental address pointers; row pointers avoid per-pixel multiplies
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ox_q       <= '0;
            oy_q       <= '0;
            row_step_q <= '0;
            plane_q    <= '0;
            feat_q     <= '0;
            row_feat_q <= '0;
            wb_q       <= '0;
            row_wb_q   <= '0;
        end else begin
            case (state)
                CALC: begin
                    row_step_q <= stride_q * fw_q;
                    plane_q    <= ow_q * oh_q;
                    ox_q       <= '0;
                    oy_q       <= '0;
                    feat_q     <= fbase_q;
                    row_feat_q <= fbase_q;
                    wb_q       <= obase_q;
                    row_wb_q   <= obase_q;
                end
                ISSUE: begin
                    if (xfer_s && !(last_col_s && last_row_s)) begin
                        if (!last_col_s) begin
                            ox_q   <= ox_q + DATA_WIDTH'(1);
                            feat_q <= feat_q + ADDR_WIDTH'(stride_q);
                            wb_q   <= wb_q + ADDR_WIDTH'(1);
                        end else begin
                            ox_q       <= '0;
                            oy_q       <= oy_q + DATA_WIDTH'(1);
                            row_feat_q <= row_feat_q + ADDR_WIDTH'(row_step_q);
                            feat_q     <= row_feat_q + ADDR_WIDTH'(row_step_q);
                            row_wb_q   <= row_wb_q + ADDR_WIDTH'(ow_q);
                            wb_q       <= row_wb_q + ADDR_WIDTH'(ow_q);
                        end
                    end
                end
                default: begin
                    ox_q <= ox_q;
                end
            endcase
        end
    end

    // Handshake outputs registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            instgen_ready_q <= 1'b1;
            inst_valid_q    <= 1'b0;
            conv_complete_q <= 1'b0;
        end else begin
            instgen_ready_q <= (state_d == IDLE);
            inst_valid_q    <= (state_d == ISSUE);
            conv_complete_q <= (state_d == DONE);
        end
    end

    assign instgen_ready           = instgen_ready_q;
    assign inst_valid              = inst_valid_q;
    assign conv_complete           = conv_complete_q;
    assign stride_feature_baseaddr = feat_q;
    assign stride_kernel_baseaddr  = kbase_q;
    assign stride_wb_baseaddr      = wb_q;
    assign stride_wb_ch_offset     = plane_q;
    assign stride_feature_chin     = chin_q;
    assign stride_feature_chout    = chout_q;
    assign stride_feature_width    = fw_q;
    assign stride_feature_height   = fh_q;
    assign stride_kernel_sizeh     = kh_q;
    assign stride_kernel_sizew     = kw_q;
    assign stride_has_bias         = bias_q;
    assign stride_has_relu         = relu_q;

endmodule

// File: tb/tb_instgen.sv
// Self-checking bench for instgen: a raster-order reference queue of expected
// instructions is compared against the DUT on every valid cycle.
module tb_instgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] feature_baseaddr, kernel_baseaddr, output_baseaddr;
    logic [31:0] feature_width, feature_height, feature_chin, feature_chout;
    logic [31:0] kernel_sizeh, kernel_sizew, stride, output_width, output_height;
    logic        has_bias, has_relu, csrcmd_valid, decoder_ready;
    logic        instgen_ready, inst_valid, conv_complete;
    logic [31:0] stride_feature_baseaddr, stride_kernel_baseaddr, stride_wb_baseaddr;
    logic [31:0] stride_feature_chin, stride_feature_chout, stride_feature_width;
    logic [31:0] stride_feature_height, stride_kernel_sizeh, stride_kernel_sizew;
    logic [31:0] stride_wb_ch_offset;
    logic        stride_has_bias, stride_has_relu;

    instgen dut (
        .clk(clk), .rst_n(rst_n),
        .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
        .output_baseaddr(output_baseaddr), .feature_width(feature_width),
        .feature_height(feature_height), .feature_chin(feature_chin),
        .feature_chout(feature_chout), .kernel_sizeh(kernel_sizeh),
        .kernel_sizew(kernel_sizew), .has_bias(has_bias), .has_relu(has_relu),
        .stride(stride), .output_width(output_width), .output_height(output_height),
        .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready),
        .inst_valid(inst_valid), .decoder_ready(decoder_ready),
        .conv_complete(conv_complete),
        .stride_feature_baseaddr(stride_feature_baseaddr),
        .stride_kernel_baseaddr(stride_kernel_baseaddr),
        .stride_wb_baseaddr(stride_wb_baseaddr),
        .stride_feature_chin(stride_feature_chin),
        .stride_feature_chout(stride_feature_chout),
        .stride_feature_width(stride_feature_width),
        .stride_feature_height(stride_feature_height),
        .stride_kernel_sizeh(stride_kernel_sizeh),
        .stride_kernel_sizew(stride_kernel_sizew),
        .stride_wb_ch_offset(stride_wb_ch_offset),
        .stride_has_bias(stride_has_bias), .stride_has_relu(stride_has_relu)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    // descriptor of the layer under test
    logic [31:0] d_fb, d_kb, d_ob, d_fw, d_fh, d_chin, d_chout, d_kh, d_kw;
    logic [31:0] d_stride, d_ow, d_oh;
    logic        d_bias, d_relu;

    // reference model state
    logic [31:0] exp_feat[$];
    logic [31:0] exp_wb[$];
    logic [31:0] exp_plane;
    logic [31:0] obs_feat[$];
    logic [31:0] obs_wb[$];

    // observations owned by the compare process
    int issued = 0, done_cnt = 0;
    int accept_cyc = -1, rise_cyc = -1, complete_cyc = -1;
    logic        prev_stall = 1'b0, prev_valid = 1'b0;
    logic [31:0] prev_feat, prev_wb;

    // snapshots taken when a layer starts
    int n_exp, ib, db, ob0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (csrcmd_valid && instgen_ready) accept_cyc = cyc;
            if (conv_complete) begin
                done_cnt++;
                complete_cyc = cyc;
            end
            if (inst_valid && !prev_valid) rise_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", 64'(inst_valid), 64'd1);
                check("stall_feat", 64'(stride_feature_baseaddr), 64'(prev_feat));
                check("stall_wb", 64'(stride_wb_baseaddr), 64'(prev_wb));
            end
            if (inst_valid) begin
                if (exp_feat.size() == 0) begin
                    check("extra_inst", 64'd1, 64'd0);
                end else begin
                    check("feat_addr", 64'(stride_feature_baseaddr), 64'(exp_feat[0]));
                    check("wb_addr", 64'(stride_wb_baseaddr), 64'(exp_wb[0]));
                    check("kernel_addr", 64'(stride_kernel_baseaddr), 64'(d_kb));
                    check("wb_ch_offset", 64'(stride_wb_ch_offset), 64'(exp_plane));
                    check("chin", 64'(stride_feature_chin), 64'(d_chin));
                    check("chout", 64'(stride_feature_chout), 64'(d_chout));
                    check("fwidth", 64'(stride_feature_width), 64'(d_fw));
                    check("fheight", 64'(stride_feature_height), 64'(d_fh));
                    check("ksizeh", 64'(stride_kernel_sizeh), 64'(d_kh));
                    check("ksizew", 64'(stride_kernel_sizew), 64'(d_kw));
                    check("bias", 64'(stride_has_bias), 64'(d_bias));
                    check("relu", 64'(stride_has_relu), 64'(d_relu));
                    if (decoder_ready) begin
                        obs_feat.push_back(stride_feature_baseaddr);
                        obs_wb.push_back(stride_wb_baseaddr);
                        void'(exp_feat.pop_front());
                        void'(exp_wb.pop_front());
                        issued++;
                    end
                end
            end
            prev_stall = inst_valid && !decoder_ready;
            prev_valid = inst_valid;
            prev_feat  = stride_feature_baseaddr;
            prev_wb    = stride_wb_baseaddr;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic set_desc(input logic [31:0] fb, kb, ob, fw, fh, chin, chout, kh, kw,
                            input logic bias, relu, input logic [31:0] st, ow, oh);
        d_fb = fb; d_kb = kb; d_ob = ob; d_fw = fw; d_fh = fh; d_chin = chin;
        d_chout = chout; d_kh = kh; d_kw = kw; d_bias = bias; d_relu = relu;
        d_stride = st; d_ow = ow; d_oh = oh;
    endtask

    task automatic drive_desc(input logic garbage);
        feature_baseaddr = garbage ? 32'hDEAD_0001 : d_fb;
        kernel_baseaddr  = garbage ? 32'hDEAD_0002 : d_kb;
        output_baseaddr  = garbage ? 32'hDEAD_0003 : d_ob;
        feature_width    = garbage ? 32'd77 : d_fw;
        feature_height   = garbage ? 32'd78 : d_fh;
        feature_chin     = garbage ? 32'd79 : d_chin;
        feature_chout    = garbage ? 32'd80 : d_chout;
        kernel_sizeh     = garbage ? 32'd5 : d_kh;
        kernel_sizew     = garbage ? 32'd6 : d_kw;
        has_bias         = garbage ? ~d_bias : d_bias;
        has_relu         = garbage ? ~d_relu : d_relu;
        stride           = garbage ? 32'd7 : d_stride;
        output_width     = garbage ? 32'd1 : d_ow;
        output_height    = garbage ? 32'd1 : d_oh;
    endtask

    // Build the expected instruction list from the layer geometry and send the command.
    task automatic start_layer();
        exp_feat.delete();
        exp_wb.delete();
        for (int y = 0; y < int'(d_oh); y++) begin
            for (int x = 0; x < int'(d_ow); x++) begin
                exp_feat.push_back(d_fb + 32'(y) * d_stride * d_fw + 32'(x) * d_stride);
                exp_wb.push_back(d_ob + 32'(y) * d_ow + 32'(x));
            end
        end
        exp_plane = d_ow * d_oh;
        n_exp = exp_feat.size();
        ib = issued;
        db = done_cnt;
        ob0 = obs_feat.size();
        @(posedge clk); #1;
        drive_desc(1'b0);
        csrcmd_valid = 1'b1;
        decoder_ready = 1'b1;
        @(posedge clk); #1;
        csrcmd_valid = 1'b0;
        drive_desc(1'b1);
    endtask

    // mode 0: decoder always ready; mode 2: random backpressure plus a stray command
    task automatic finish_layer(input int mode);
        int k;
        k = 0;
        while (done_cnt == db && k < 4 * n_exp + 40) begin
            if (mode == 2) begin
                decoder_ready = 1'($urandom_range(0, 1));
                csrcmd_valid  = (k >= 3 && k < 6);
            end
            @(posedge clk); #1;
            k++;
        end
        csrcmd_valid = 1'b0;
        decoder_ready = 1'b1;
        check("done_seen", 64'(done_cnt != db), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("inst_count", 64'(issued - ib), 64'(n_exp));
        check("done_pulses", 64'(done_cnt - db), 64'd1);
        check("model_drained", 64'(exp_feat.size()), 64'd0);
        check("state_idle", 64'(dut.state), 64'd0);
        check("ready_idle", 64'(instgen_ready), 64'd1);
        if (mode == 0) begin
            if (n_exp > 0) begin
                check("lat_first", 64'(rise_cyc - accept_cyc), 64'd2);
                check("lat_done", 64'(complete_cyc - rise_cyc), 64'(n_exp));
            end else begin
                check("lat_zero", 64'(complete_cyc - accept_cyc), 64'd2);
            end
        end
    endtask

    initial begin
        int k;
        logic [31:0] s2_feat [9];
        s2_feat = '{32'd0, 32'd2, 32'd4, 32'd16, 32'd18, 32'd20, 32'd32, 32'd34, 32'd36};
        rst_n = 1'b1;
        csrcmd_valid = 1'b0;
        decoder_ready = 1'b1;
        set_desc(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        drive_desc(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(dut.state), 64'd0);
        check("rst_ready", 64'(instgen_ready), 64'd1);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_done", 64'(conv_complete), 64'd0);
        check("rst_feat", 64'(stride_feature_baseaddr), 64'd0);
        check("rst_offset", 64'(stride_wb_ch_offset), 64'd0);
        rst_n = 1'b0;

        // nominal 28x28 layer, 3x3 kernel, 26x26 output
        set_desc(32'd0, 32'h0002_0000, 32'h0001_0000, 32'd28, 32'd28, 32'd3, 32'd64,
                 32'd3, 32'd3, 1'b1, 1'b1, 32'd1, 32'd26, 32'd26);
        start_layer();
        finish_layer(0);
        check("nom_obs", 64'(obs_feat.size() - ob0), 64'd676);
        if (obs_feat.size() - ob0 >= 676) begin
            check("nom_feat0", 64'(obs_feat[ob0]), 64'd0);
            check("nom_wb0", 64'(obs_wb[ob0]), 64'h1_0000);
            check("nom_feat26", 64'(obs_feat[ob0 + 26]), 64'd28);
            check("nom_wb26", 64'(obs_wb[ob0 + 26]), 64'h1_001A);
            check("nom_feat_last", 64'(obs_feat[ob0 + 675]), 64'd725);
            check("nom_wb_last", 64'(obs_wb[ob0 + 675]), 64'h1_02A3);
        end

        // stride 2, 8x8 input, 3x3 output
        set_desc(32'd0, 32'h300, 32'h5000, 32'd8, 32'd8, 32'd1, 32'd8,
                 32'd3, 32'd3, 1'b0, 1'b0, 32'd2, 32'd3, 32'd3);
        start_layer();
        finish_layer(0);
        check("s2_obs", 64'(obs_feat.size() - ob0), 64'd9);
        if (obs_feat.size() - ob0 >= 9) begin
            for (int i = 0; i < 9; i++) begin
                check("s2_feat", 64'(obs_feat[ob0 + i]), 64'(s2_feat[i]));
            end
        end

        // backpressure, address wrap-around and a command ignored during issue
        set_desc(32'hFFFF_FFF0, 32'h40, 32'h8000, 32'd10, 32'd9, 32'd4, 32'd16,
                 32'd3, 32'd2, 1'b0, 1'b1, 32'd1, 32'd9, 32'd8);
        start_layer();
        finish_layer(2);

        // zero-width output
        set_desc(32'h100, 32'h200, 32'h300, 32'd4, 32'd4, 32'd1, 32'd1,
                 32'd1, 32'd1, 1'b1, 1'b0, 32'd1, 32'd0, 32'd5);
        start_layer();
        finish_layer(0);

        // abort by reset after 10 instructions
        set_desc(32'h0, 32'h10, 32'h2000, 32'd12, 32'd12, 32'd2, 32'd2,
                 32'd2, 32'd2, 1'b1, 1'b1, 32'd2, 32'd6, 32'd4);
        start_layer();
        k = 0;
        while (issued - ib < 10 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_reached", 64'(issued - ib >= 10), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        check("abort_state", 64'(dut.state), 64'd0);
        check("abort_valid", 64'(inst_valid), 64'd0);
        check("abort_ready", 64'(instgen_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - db), 64'd0);
        exp_feat.delete();
        exp_wb.delete();

        // fresh command after the abort restarts at pixel (0,0)
        set_desc(32'h100, 32'h20, 32'h4000, 32'd6, 32'd5, 32'd3, 32'd3,
                 32'd3, 32'd3, 1'b0, 1'b1, 32'd1, 32'd4, 32'd3);
        start_layer();
        finish_layer(0);
        if (obs_feat.size() > ob0) begin
            check("restart_feat0", 64'(obs_feat[ob0]), 64'h100);
            check("restart_wb0", 64'(obs_wb[ob0]), 64'h4000);
        end else begin
            check("restart_obs", 64'(obs_feat.size() - ob0), 64'd12);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instgen.md
Name: instgen

Overview:
- Convolution instruction generator between the CSR command interface and the instruction decoder.
- Latches one convolution layer descriptor and emits one "stride" instruction per output pixel, raster order (row-major, oy outer, ox inner).
- Each instruction carries the window/kernel/write-back addresses and layer attributes; pulses conv_complete after the last one is accepted.

Parameters:
- ADDR_WIDTH, 32, address width (`ADDR_WIDTH).
- DATA_WIDTH, 32, scalar field width (`XLEN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1 despite the suffix).
- feature_baseaddr, kernel_baseaddr, output_baseaddr  in  ADDR_WIDTH  input feature map, kernel and output base addresses (element units).
- feature_width, feature_height, feature_chin, feature_chout  in  DATA_WIDTH  input map geometry and channel counts.
- kernel_sizeh, kernel_sizew  in  DATA_WIDTH  kernel height/width.
- has_bias, has_relu  in  1  layer flags.
- stride  in  DATA_WIDTH  convolution stride (same in both dimensions).
- output_width, output_height  in  DATA_WIDTH  output map geometry.
- csrcmd_valid  in  1  descriptor valid.
- instgen_ready  out  1  descriptor accepted when high with csrcmd_valid.
- inst_valid  out  1  instruction valid.
- decoder_ready  in  1  decoder accepts instruction.
- conv_complete  out  1  one-cycle done pulse.
- stride_feature_baseaddr, stride_kernel_baseaddr, stride_wb_baseaddr  out  ADDR_WIDTH  per-instruction addresses.
- stride_feature_chin, stride_feature_chout, stride_feature_width, stride_feature_height, stride_kernel_sizeh, stride_kernel_sizew, stride_wb_ch_offset  out  DATA_WIDTH  per-instruction fields.
- stride_has_bias, stride_has_relu  out  1  per-instruction flags.

Behaviour:
- Register named state (hierarchically visible). Encoding: IDLE=0, CALC=1, ISSUE=2, DONE=3.
- Reset (rst_n=1 at a rising edge): state=IDLE, all outputs 0 except instgen_ready=1, counters ox=oy=0. Reset mid-operation aborts; no conv_complete.
- IDLE: instgen_ready=1, inst_valid=0.
  - On csrcmd_valid, latch all descriptor inputs and go to CALC.
  - Descriptor inputs are ignored in every other state.
- CALC (1 cycle), instgen_ready=0. Precompute:
  - row_step = stride*feature_width
  - col_step = stride
  - plane = output_width*output_height (all truncated to DATA_WIDTH)
  - ox=oy=0; row pointers set to the base addresses.
  - If output_width==0 or output_height==0, go to DONE; else go to ISSUE.
- ISSUE: inst_valid=1. For current (oy, ox):
  - stride_feature_baseaddr = feature_baseaddr + oy*row_step + ox*stride
  - stride_kernel_baseaddr = kernel_baseaddr
  - stride_wb_baseaddr = output_baseaddr + oy*output_width + ox
  - stride_wb_ch_offset = plane
  - All other stride_* outputs = latched descriptor fields (chin, chout, width, height, ksizeh, ksizew, bias, relu).
  - Addresses computed incrementally (adders, no per-pixel multiply); arithmetic modulo 2^ADDR_WIDTH.
- Handshake: transfer on inst_valid && decoder_ready.
  - All stride_* outputs are stable while inst_valid=1 and decoder_ready=0.
  - Throughput: one instruction per cycle when decoder_ready held high.
- Advance on transfer:
  - ox<output_width-1: ox++.
  - Else ox=0, oy++.
  - Transfer of pixel (output_height-1, output_width-1) goes to DONE; inst_valid drops the next cycle.
- DONE (1 cycle): conv_complete=1, inst_valid=0, instgen_ready=0; then IDLE. stride_* outputs keep their last values.
- Latency: descriptor accept edge -> CALC next cycle -> first inst_valid the cycle after. With decoder_ready always high, conv_complete asserts exactly N cycles after the first inst_valid cycle, N = output_width*output_height.

Test Plan:
- Reset: rst_n=1 for 2 cycles -> state=0, instgen_ready=1, inst_valid=0, conv_complete=0.
- Nominal layer (28x28x3, chout 64, 3x3 kernel, stride 1, bias/relu=1, out 26x26 at 0x10000), one-cycle csrcmd_valid, decoder_ready=1:
  - Exactly 676 instructions issued.
  - First instruction: feature addr 0, wb 0x10000.
  - Instruction index 26: feature addr 28, wb 0x1001A.
  - Last instruction: feature addr 25*28+25=725, wb 0x10000+675.
  - stride_wb_ch_offset=676 throughout; one conv_complete pulse; state returns to 0.
- Stride 2 (8x8 in, out 3x3, 3x3 kernel): feature addrs 0, 2, 4, 16, 18, 20, 32, 34, 36; 9 instructions; conv_complete once.
- Backpressure: toggle decoder_ready pseudo-randomly -> no instruction lost or duplicated, outputs stable while stalled, count=N.
- Zero-size output (output_width=0) -> no inst_valid, conv_complete pulses 2 cycles after accept.
- Mid-run reset after 10 instructions -> IDLE next cycle, no conv_complete; a new command then runs normally from pixel (0,0). csrcmd_valid during ISSUE is ignored.
